// File: rtl/deadtime_scaler_multi.sv
// deadtime_scaler_multi: per-channel dead-time scalers latched once per PPS second.
// Each channel prescales its dead clocks by 2^PRESCALE_BITS and accumulates the result.
// At every PPS the accumulator is clamped into an OUT_BITS-wide field starting at
// OUT_SHIFT, and the field is latched as that channel's scaler for the second.
// Optional feature: define DEADTIME_SAT_FLAG_EN to add sat_o, a per-channel flag
// that marks scalers clamped at capture.
module deadtime_scaler_multi #(
  parameter int NCH           = 4,
  parameter int PRESCALE_BITS = 5,
  parameter int ACC_BITS      = 24,
  parameter int OUT_SHIFT     = 6,
  parameter int OUT_BITS      = 16,
  localparam int SEL_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NCH-1:0]          dead_i,
  input  logic                    pps_i,
  input  logic [SEL_W-1:0]        sel_i,
  output logic [NCH*OUT_BITS-1:0] deadtime_o,
  output logic [OUT_BITS-1:0]     rd_data_o,
  output logic                    valid_o
`ifdef DEADTIME_SAT_FLAG_EN
  ,
  output logic [NCH-1:0]          sat_o
`endif
);

  logic [PRESCALE_BITS-1:0] presc  [NCH];
  logic [ACC_BITS-1:0]      acc    [NCH];
  logic [OUT_BITS-1:0]      scaler [NCH];
  logic                     vld_p1;
  logic [OUT_BITS-1:0]      rd_sel;
  logic [OUT_BITS-1:0]      rd_p1;

  // An accumulator is saturated when any bit above the reported field is set,
  // or when it has stuck at all-ones.
  function automatic logic is_saturated(input logic [ACC_BITS-1:0] a);
    logic hit;
    hit = &a;
    for (int i = OUT_SHIFT + OUT_BITS; i < ACC_BITS; i++) begin
      hit = hit | a[i];
    end
    return hit;
  endfunction

  // Reported field of the accumulator, forced to all-ones when saturated.
  function automatic logic [OUT_BITS-1:0] clamp_field(input logic [ACC_BITS-1:0] a);
    if (is_saturated(a)) begin
      return '1;
    end
    return OUT_BITS'(a >> OUT_SHIFT);
  endfunction

  // Per-channel prescale/accumulate; PPS latches the scaler and restarts the second.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NCH; k++) begin
        presc[k]  <= '0;
        acc[k]    <= '0;
        scaler[k] <= '0;
      end
`ifdef DEADTIME_SAT_FLAG_EN
      sat_o <= '0;
`endif
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (pps_i) begin
          // A dead PPS cycle already belongs to the new second; its carry is dropped.
          scaler[k] <= clamp_field(acc[k]);
          acc[k]    <= '0;
          presc[k]  <= PRESCALE_BITS'(dead_i[k]);
`ifdef DEADTIME_SAT_FLAG_EN
          sat_o[k]  <= is_saturated(acc[k]);
`endif
        end else if (dead_i[k]) begin
          presc[k] <= presc[k] + 1'b1;
          if (&presc[k] && !(&acc[k])) begin
            acc[k] <= acc[k] + 1'b1;
          end
        end
      end
    end
  end

  // Stage p1: valid pulse follows the PPS cycle, aligned with the new scalers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= pps_i;
    end
  end

  // Read-mux selection; out-of-range selects read as zero.
  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel_i == SEL_W'(k)) begin
        rd_sel = scaler[k];
      end
    end
  end

  // Stage p1: registered read-mux output.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_p1 <= '0;
    end else begin
      rd_p1 <= rd_sel;
    end
  end

  // Pack latched scalers onto the status bus.
  always_comb begin
    deadtime_o = '0;
    for (int k = 0; k < NCH; k++) begin
      deadtime_o[k*OUT_BITS +: OUT_BITS] = scaler[k];
    end
  end

  assign valid_o   = vld_p1;
  assign rd_data_o = rd_p1;

endmodule
